firram_loader: RTL and testbench

FIRRAM_LOADER -- requirements
Module: firram_loader

---
 rtl/firram_loader.sv | 155 +++++++++++++++
 tb/tb_firram_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/firram_loader.sv
`default_nettype none
// ============================================================================
// Module      : firram_loader
// Description : Loads a DEPTH x DATA_W FIR coefficient table from a
//               valid/ready stream and exposes it on a registered read port.
//               A start pulse (re)starts a load from address 0. The table is
//               flagged valid once all DEPTH words have been written.
// Ports       : clock        - single clock, rising edge
//               reset        - synchronous active-high reset
//               start        - load request pulse
//               s_data       - coefficient stream data (two's complement)
//               s_valid      - s_data is valid
//               s_ready      - block accepts s_data this cycle
//               rd_address   - FIR-side read address
//               rd_q         - FIR-side read data (1-cycle latency)
//               busy         - a load is in progress
//               table_valid  - table completely loaded since last start/reset
//               count        - words written in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module firram_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 18,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [DATA_W-1:0] rd_q,
    output logic              busy,
    output logic              table_valid,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_count_one = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W:0]     r_count;
    logic                r_table_valid;
    logic                w_we;
    logic                w_clr;
    logic                w_last;

    logic [DATA_W-1:0]   mem [DEPTH];

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        busy        = 1'b0;
        w_we        = 1'b0;
        w_clr       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_clr       = 1'b1;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (start) begin
                    // Restart: any handshake offered this cycle is dropped.
                    w_clr = 1'b1;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        w_we = 1'b1;
                        if (r_wr_addr == c_last_addr) begin
                            w_last      = 1'b1;
                            w_state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_clr       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Reset wins over any transfer; never advertise readiness under it.
        if (reset) begin
            s_ready = 1'b0;
            w_we    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and load bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wr_addr     <= '0;
            r_count       <= '0;
            r_table_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr) begin
                r_wr_addr     <= '0;
                r_count       <= '0;
                r_table_valid <= 1'b0;
            end else if (w_we) begin
                r_count <= r_count + c_count_one;
                // Hold the address on the final word so it never wraps.
                if (w_last) begin
                    r_table_valid <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + c_addr_one;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Simple dual-port table. Contents survive reset; the read port runs
    // unconditionally and returns old data on a same-address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_we) begin
            mem[r_wr_addr] <= s_data;
        end
    end

    always_ff @(posedge clock) begin
        rd_q <= mem[rd_address];
    end

    assign count       = r_count;
    assign table_valid = r_table_valid;

endmodule
`default_nettype wire

// File: tb/tb_firram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_firram_loader
// Description : Self-checking bench for firram_loader. A behavioural table
//               model (array + load index) predicts memory contents, count,
//               busy, table_valid and s_ready from the stream rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_firram_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 256;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] rd_address;
    logic [DATA_W-1:0] rd_q;
    logic              busy;
    logic              table_valid;
    logic [ADDR_W:0]   count;

    firram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .rd_address  (rd_address),
        .rd_q        (rd_q),
        .busy        (busy),
        .table_valid (table_valid),
        .count       (count)
    );

    always #5 clock = ~clock;

    // Reference model
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                ref_idx;
    bit                ref_loading;
    bit                ref_tv;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given stream inputs; model follows the load rules.
    task automatic step(input bit st, input bit v, input logic [DATA_W-1:0] d);
        start   = st;
        s_valid = v;
        s_data  = d;
        @(posedge clock);
        #1;
        if (st) begin
            ref_loading = 1'b1;
            ref_idx     = 0;
            ref_tv      = 1'b0;
        end else if (ref_loading && v) begin
            ref_mem[ref_idx] = d;
            ref_idx++;
            if (ref_idx == DEPTH) begin
                ref_loading = 1'b0;
                ref_tv      = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int n, input bit st, input bit v);
        reset   = 1'b1;
        start   = st;
        s_valid = v;
        s_data  = DATA_W'($urandom);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
        reset       = 1'b0;
        start       = 1'b0;
        s_valid     = 1'b0;
        ref_loading = 1'b0;
        ref_idx     = 0;
        ref_tv      = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"},  32'(busy),        32'(ref_loading));
        check({tag, "_count"}, 32'(count),       32'(ref_idx));
        check({tag, "_tv"},    32'(table_valid), 32'(ref_tv));
        check({tag, "_ready"}, 32'(s_ready),     32'(ref_loading && !start));
    endtask

    task automatic sweep(input string tag);
        start   = 1'b0;
        s_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_address = ADDR_W'(a);
            @(posedge clock);
            #1;
            check(tag, 32'(rd_q), 32'(ref_mem[a]));
        end
    endtask

    // Start pulse followed by a full back-to-back load of random words,
    // optionally forcing one location to a fixed value.
    task automatic random_load(input int force_a, input logic [DATA_W-1:0] force_d);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, (i == force_a) ? force_d : DATA_W'($urandom));
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        rd_address = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        ref_idx     = 0;
        ref_loading = 1'b0;
        ref_tv      = 1'b0;

        // Reset with start and valid asserted: reset must dominate.
        do_reset(3, 1'b1, 1'b1);
        check_status("reset");

        // Full load, value = index*3, busy through all 256 words.
        step(1'b1, 1'b0, '0);
        check_status("full_start");
        for (int i = 0; i < DEPTH; i++) begin
            check({"full_busy_pre"}, 32'(busy), 32'd1);
            step(1'b0, 1'b1, DATA_W'(i * 3));
        end
        check_status("full_done");
        check("full_count256", 32'(count), 32'd256);
        rd_address = 8'd10;
        start = 1'b0; s_valid = 1'b0;
        @(posedge clock); #1;
        check("full_rd10", 32'(rd_q), 32'd30);
        sweep("full_mem");

        // Idle robustness: valid without start after reset.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, DATA_W'($urandom));
            check_status("idle");
        end
        sweep("idle_mem");

        // Throttled source, data counting down from 0x3FFFF.
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b1, DATA_W'(18'h3FFFF - i / 2));
            else            step(1'b0, 1'b0, DATA_W'($urandom));
            check_status("thr");
        end
        check("thr_count", 32'(count), 32'd256);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, DATA_W'($urandom));
            check_status("thr_extra");
        end
        sweep("thr_mem");

        // Restart mid-load at count 100.
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, DATA_W'($urandom));
        check("rst_count100", 32'(count), 32'd100);
        step(1'b1, 1'b1, DATA_W'($urandom));
        check_status("restart");
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 18'h00001);
            check_status("restart_load");
        end
        check("restart_tv", 32'(table_valid), 32'd1);
        sweep("restart_mem");

        // Reset mid-load at count 50 over freshly randomised old contents.
        random_load(-1, '0);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, DATA_W'($urandom));
        check("abort_count50", 32'(count), 32'd50);
        do_reset(1, 1'b0, 1'b1);
        check_status("abort");
        sweep("abort_mem");

        // Same-address collision on location 5.
        random_load(5, 18'h00AAA);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DATA_W'($urandom));
        rd_address = 8'd5;
        step(1'b0, 1'b1, 18'h12345);
        check("coll_old", 32'(rd_q), 32'h00AAA);
        step(1'b0, 1'b1, DATA_W'($urandom));
        check("coll_new", 32'(rd_q), 32'h12345);
        for (int i = 7; i < DEPTH; i++) step(1'b0, 1'b1, DATA_W'($urandom));
        check_status("coll_done");
        sweep("coll_mem");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
